seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Downstream display stage for the clock page.
- Consumes the 32-bit packed time word: eight 4-bit codes, position 7 at bits [31:28] down to position 0 at bits [3:0].
- Time-multiplexes the codes onto the board's two 4-digit 7-segment groups (digit1 = positions 7..4, digit2 = positions 3..0).
- Adds frame-coherent latching, per-position blinking for the adjust cursor, and per-position decimal points.

Parameters:
- SCAN_DIV, 100_000: clk cycles per scan slot; 1 kHz slot rate, 250 Hz frame rate at 100 MHz. Legal minimum is 2.
- BLINK_DIV, 25_000_000: clk cycles per blink phase toggle; 2 Hz at 100 MHz. Legal minimum is 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- en  in  1  display enable; 0 forces all tubes off
- time_data  in  32  eight packed display codes
- blink_mask  in  8  bit i=1: position i blinks
- dp_mask  in  8  bit i=1: decimal point lit at position i
- digit1  out  8  segments for the left group
- digit2  out  8  segments for the right group
- tube_sel  out  8  one-hot-per-group tube enables, active-high

Behaviour:
- Segment bit order: [7]=a, [6]=b, [5]=c, [4]=d, [3]=e, [2]=f, [1]=g, [0]=dp. Segments are active-high.
- Code map: 0-9 render the digits; 10-13 render A, b, C, d; 14 renders blank (8'h00); 15 renders dash (g only, 8'h02).
- Reset (rst=0, async):
  - scan_cnt=0, slot=0, blink_cnt=0, blink_phase=0.
  - Shadow register = 32'hEEEE_EEEE (all blank); load_pending=1.
  - digit1=digit2=8'h00, tube_sel=8'h00.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and slot increments mod 4.
- Shadow load:
  - Condition: the slot 3->0 transition, or load_pending=1. Load_pending clears on that load, so the first load is 1 clk after reset release.
  - Shadow captures time_data, blink_mask and dp_mask together.
  - Mid-frame input changes are never displayed until the next frame.
- Slot s mapping:
  - Left group shows position 7-s and drives tube_sel[7-s].
  - Right group shows position 3-s and drives tube_sel[3-s].
  - Exactly two tube_sel bits are high when en=1.
- Outputs are registered and reflect the current slot 1 clk after the slot changes.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; at terminal count blink_phase toggles.
  - The counter is free-running and is not re-aligned when the mask changes.
  - When blink_phase=1 and shadow blink bit i=1, position i segments (including dp) are 8'h00. Its tube_sel bit stays asserted, so the scan timing is unchanged.
- Decimal point: shadow dp bit i ORs into segment bit [0] for position i, unless that position is blinked off.
- Enable:
  - en=0 forces tube_sel=8'h00 and digit1=digit2=8'h00 on the next clk.
  - The scan, blink and shadow logic keep running while en=0.
  - en 0->1 resumes at the current slot, with no restart.
- Simultaneous events:
  - Scan terminal count and blink terminal count in the same cycle: both take effect; the output on the next clk uses the new slot and the new phase.
  - Shadow load and slot 3->0 in the same cycle: slot 0 uses the newly loaded data.
- Reset mid-operation: all state returns to reset values immediately, and the tubes blank asynchronously.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: position 7 renders blank when its shadow code is 0 (for example hour 05 shows " 5"). Positions 6..0 are unaffected, and dp/blink still apply.
- Undefined: position 7 renders "0" normally.

Decomposition:
- Shared package seg_pkg holds:
  - the segment bit-order localparams;
  - code constants SEG_CODE_BLANK=4'hE and SEG_CODE_DASH=4'hF;
  - the 16-entry segment pattern table;
  - the slot width (2 bits).
- Sub-module seg_decoder: combinational, 4-bit code in, 8-bit pattern out, instantiated twice (one per group).
- Top level holds the counters, shadow register, blink/dp masking and output registers.

Test Plan:
- SCAN_DIV=4, en=1, time_data=32'h12F3_4F56, masks 0 -> over 16 clk after the first load:
  - tube_sel cycles 8'h88, 8'h44, 8'h22, 8'h11.
  - digit1 = "1", "2", dash, "3".
  - digit2 = "4", dash, "5", "6".
- Change time_data while slot=1 -> outputs keep the old codes until slot 0 of the next frame, then show the new codes.
- BLINK_DIV=16, blink_mask=8'h01, time_data=32'h0000_0009:
  - Position 0 alternates "9" (8'hF6) and 8'h00 every 16 clk.
  - tube_sel[0] still asserts in slot 3.
- dp_mask=8'h20, code 4 at position 5 -> digit1 = 8'h67 during slot 2.
- Toggle en 1->0 -> next clk tube_sel=8'h00 and digits 8'h00. Re-enable -> the scan resumes at the current slot.
- Assert rst mid-slot -> outputs 8'h00 immediately. After release, outputs are blank until the first shadow load 1 clk later.
- With SEG_LEADING_ZERO_BLANK_EN defined, time_data=32'h05F0_0F00 -> slot 0 digit1=8'h00.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order, special
// codes, the code-to-pattern table and the scan slot width.
package seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [3:0] SEG_CODE_BLANK = 4'hE;
    localparam logic [3:0] SEG_CODE_DASH  = 4'hF;

    localparam int SLOT_W = 2;
    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [7:0]        seg_t;

    // Entry [n] is the active-high pattern for code n; 10..13 are A b C d.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h02, 8'h00, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    function automatic seg_t seg_pattern(input logic [3:0] code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit display code to 7-segment pattern lookup.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = seg_pattern(code);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans eight packed display codes onto two 4-digit 7-segment groups with
// frame-coherent latching, blinking and decimal points. Optional macro:
// SEG_LEADING_ZERO_BLANK_EN blanks position 7 when its code is 0.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] time_data,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);

    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [7:0]         DP_BIT     = 8'(1) << SEG_DP;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    slot_t              slot;
    logic               blink_phase;
    logic               load_pending;
    logic [31:0]        sh_time;
    logic [7:0]         sh_blink;
    logic [7:0]         sh_dp;

    logic        scan_tc;
    logic        blink_tc;
    logic        load_now;
    logic [2:0]  pos_l;
    logic [2:0]  pos_r;
    logic [3:0]  code_l;
    logic [3:0]  code_r;
    logic [7:0]  pat_l;
    logic [7:0]  pat_r;
    logic [7:0]  pat_l_lz;
    logic [7:0]  seg_l_next;
    logic [7:0]  seg_r_next;
    logic [7:0]  sel_next;

    assign scan_tc  = (scan_cnt == SCAN_LAST);
    assign blink_tc = (blink_cnt == BLINK_LAST);
    // A frame boundary doubles as the load point, so slot 0 always sees fresh data.
    assign load_now = (scan_tc && (slot == slot_t'(3))) || load_pending;

    // Slot s shows position 7-s on the left group and 3-s on the right group.
    assign pos_l  = {1'b1, ~slot};
    assign pos_r  = {1'b0, ~slot};
    assign code_l = sh_time[{pos_l, 2'b00} +: 4];
    assign code_r = sh_time[{pos_r, 2'b00} +: 4];

    seg_decoder u_dec_l (
        .code    (code_l),
        .pattern (pat_l)
    );

    seg_decoder u_dec_r (
        .code    (code_r),
        .pattern (pat_r)
    );

    always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
        pat_l_lz = ((pos_l == 3'd7) && (code_l == 4'h0)) ? 8'h00 : pat_l;
`else
        pat_l_lz = pat_l;
`endif
    end

    always_comb begin
        seg_l_next = 8'h00;
        seg_r_next = 8'h00;
        sel_next   = 8'h00;
        if (en) begin
            sel_next = (8'h80 >> slot) | (8'h08 >> slot);
            if (!(blink_phase && sh_blink[pos_l])) begin
                seg_l_next = pat_l_lz | (sh_dp[pos_l] ? DP_BIT : 8'h00);
            end
            if (!(blink_phase && sh_blink[pos_r])) begin
                seg_r_next = pat_r | (sh_dp[pos_r] ? DP_BIT : 8'h00);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt    <= '0;
            slot        <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (scan_tc) begin
                scan_cnt <= '0;
                slot     <= slot + slot_t'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            if (blink_tc) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_time      <= {8{SEG_CODE_BLANK}};
            sh_blink     <= 8'h00;
            sh_dp        <= 8'h00;
            load_pending <= 1'b1;
        end else if (load_now) begin
            sh_time      <= time_data;
            sh_blink     <= blink_mask;
            sh_dp        <= dp_mask;
            load_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit1   <= 8'h00;
            digit2   <= 8'h00;
            tube_sel <= 8'h00;
        end else begin
            digit1   <= seg_l_next;
            digit2   <= seg_r_next;
            tube_sel <= sel_next;
        end
    end

endmodule
